// File: rtl/cpu19_pkg.sv
// Shared widths and enums for the 19-bit CPU memory-port arbiter.
package cpu19_pkg;
  localparam int DATA_W = 19;
  localparam int ADDR_W = 19;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;
  typedef enum logic {REQ_IF, REQ_DM} req_id_t;
endpackage

// File: rtl/mem_arb_pick.sv
// Winner select for the memory port: DM has fixed priority unless IF has
// lost STARVE_MAX arbitrations in a row.
module mem_arb_pick
  import cpu19_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    i_if_req,
  input  logic    i_dm_req,
  input  logic    i_arb_en,
  output req_id_t o_winner
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] r_starve_cnt;
  logic       w_dm_wins;

  assign w_dm_wins = i_dm_req && (!i_if_req || (r_starve_cnt < STARVE_LIM));
  assign o_winner  = w_dm_wins ? REQ_DM : REQ_IF;

  // Counter only moves on an actual arbitration; any IF win or idle IF clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (i_arb_en) begin
      if (i_if_req && w_dm_wins)
        r_starve_cnt <= (r_starve_cnt == STARVE_LIM) ? r_starve_cnt : r_starve_cnt + 4'd1;
      else
        r_starve_cnt <= '0;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-ported I/D memory between fetch (IF) and data (DM).
// Define RDATA_REG_EN to register read data and return it one cycle later.
module mem_port_arbiter
  import cpu19_pkg::*;
#(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_gnt,
  output logic              o_if_rvalid,
  output logic [DATA_W-1:0] o_if_rdata,
  input  logic              i_dm_req,
  input  logic              i_dm_we,
  input  logic [ADDR_W-1:0] i_dm_addr,
  input  logic [DATA_W-1:0] i_dm_wdata,
  output logic              o_dm_gnt,
  output logic              o_dm_rvalid,
  output logic [DATA_W-1:0] o_dm_rdata,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_busy
);

  localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

  arb_state_t        r_state, w_state_next;
  req_id_t           r_id, w_winner;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [3:0]        r_lat, w_lat_next;
  logic              w_arb_en, w_issue, w_rvalid, w_if_rv, w_dm_rv;
  logic [DATA_W-1:0] w_rdata;
`ifdef RDATA_REG_EN
  logic [DATA_W-1:0] r_rdata;
`endif

  assign w_arb_en = (r_state == IDLE) && (i_if_req || i_dm_req);

  mem_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_if_req (i_if_req),
    .i_dm_req (i_dm_req),
    .i_arb_en (w_arb_en),
    .o_winner (w_winner)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_lat   <= '0;
    end else begin
      r_state <= w_state_next;
      r_lat   <= w_lat_next;
    end
  end

  // Fetches are always reads; IF carries no write data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id    <= REQ_IF;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_arb_en) begin
      r_id    <= w_winner;
      r_we    <= (w_winner == REQ_DM) && i_dm_we;
      r_addr  <= (w_winner == REQ_DM) ? i_dm_addr : i_if_addr;
      r_wdata <= (w_winner == REQ_DM) ? i_dm_wdata : '0;
    end
  end

`ifdef RDATA_REG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_rdata <= '0;
    else if ((r_state == WAIT) && (r_lat == '0))
      r_rdata <= i_mem_rdata;
  end
`endif

  always_comb begin
    w_state_next = r_state;
    w_lat_next   = r_lat;
    w_issue      = 1'b0;
    w_rvalid     = 1'b0;
    w_rdata      = '0;
    case (r_state)
      IDLE: begin
        if (w_arb_en) w_state_next = ISSUE;
      end
      ISSUE: begin
        w_issue = 1'b1;
        if (r_we) begin
          w_state_next = IDLE;
        end else begin
          w_lat_next   = LAT_LOAD;
          w_state_next = WAIT;
        end
      end
      WAIT: begin
        if (r_lat != '0) begin
          w_lat_next = r_lat - 4'd1;
        end else begin
`ifdef RDATA_REG_EN
          w_state_next = RESP;
`else
          w_rvalid     = 1'b1;
          w_rdata      = i_mem_rdata;
          w_state_next = IDLE;
`endif
        end
      end
      RESP: begin
`ifdef RDATA_REG_EN
        w_rvalid = 1'b1;
        w_rdata  = r_rdata;
`endif
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_if_rv     = w_rvalid && (r_id == REQ_IF);
  assign w_dm_rv     = w_rvalid && (r_id == REQ_DM);
  assign o_if_gnt    = w_issue && (r_id == REQ_IF);
  assign o_dm_gnt    = w_issue && (r_id == REQ_DM);
  assign o_if_rvalid = w_if_rv;
  assign o_dm_rvalid = w_dm_rv;
  assign o_if_rdata  = w_if_rv ? w_rdata : '0;
  assign o_dm_rdata  = w_dm_rv ? w_rdata : '0;
  assign o_mem_en    = w_issue;
  assign o_mem_we    = w_issue && r_we;
  assign o_mem_addr  = w_issue ? r_addr : '0;
  assign o_mem_wdata = w_issue ? r_wdata : '0;
  assign o_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random
// traffic against a transaction-schedule model; honours RDATA_REG_EN.
module tb_mem_port_arbiter;
  import cpu19_pkg::*;

  localparam int L    = 2;
  localparam int SMAX = 4;
`ifdef RDATA_REG_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif
  localparam int RV_OFF   = 1 + L + EXTRA;   // request cycle -> RVALID cycle
  localparam int SPACE_RD = L + 2 + EXTRA;   // grant-to-grant for reads

  typedef struct packed {
    logic        if_gnt;
    logic        dm_gnt;
    logic        if_rv;
    logic [18:0] if_rd;
    logic        dm_rv;
    logic [18:0] dm_rd;
    logic        en;
    logic        we;
    logic [18:0] addr;
    logic [18:0] wdata;
    logic        busy;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_if_req, i_dm_req, i_dm_we;
  logic [18:0] i_if_addr, i_dm_addr, i_dm_wdata, i_mem_rdata;
  logic        o_if_gnt, o_if_rvalid, o_dm_gnt, o_dm_rvalid;
  logic        o_mem_en, o_mem_we, o_busy;
  logic [18:0] o_if_rdata, o_dm_rdata, o_mem_addr, o_mem_wdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LAT(L), .STARVE_MAX(SMAX)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_if_req    (i_if_req),
    .i_if_addr   (i_if_addr),
    .o_if_gnt    (o_if_gnt),
    .o_if_rvalid (o_if_rvalid),
    .o_if_rdata  (o_if_rdata),
    .i_dm_req    (i_dm_req),
    .i_dm_we     (i_dm_we),
    .i_dm_addr   (i_dm_addr),
    .i_dm_wdata  (i_dm_wdata),
    .o_dm_gnt    (o_dm_gnt),
    .o_dm_rvalid (o_dm_rvalid),
    .o_dm_rdata  (o_dm_rdata),
    .o_mem_en    (o_mem_en),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_rdata (i_mem_rdata),
    .o_busy      (o_busy)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic        s_rst_n, s_if_req, s_dm_req, s_dm_we;
  logic [18:0] s_if_addr, s_dm_addr, s_dm_wdata;

  obs_t got;
  obs_t exp_q [64];
  bit   wd_care [64];
  bit   chk_en = 1'b0;
  int   free_cyc = 0;
  int   starve = 0;

  logic [18:0] mem [logic [18:0]];
  bit          pend_v [32];
  logic [18:0] pend_a [32];

  function automatic logic [18:0] mem_peek(input logic [18:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 19'h2AAAA;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, req);
    end
  endtask

  // Transaction-level model: one arbitration schedules every output of the
  // whole transaction into future cycle slots.
  task automatic model_arb();
    bit          dmw;
    int          s, last;
    logic [18:0] a;
    if (cyc >= free_cyc && (i_if_req || i_dm_req)) begin
      dmw = i_dm_req && (!i_if_req || starve < SMAX);
      if (i_if_req && dmw) starve = (starve < SMAX) ? starve + 1 : SMAX;
      else starve = 0;
      a = dmw ? i_dm_addr : i_if_addr;
      s = (cyc + 1) % 64;
      exp_q[s].if_gnt = !dmw;
      exp_q[s].dm_gnt = dmw;
      exp_q[s].en     = 1'b1;
      exp_q[s].addr   = a;
      exp_q[s].busy   = 1'b1;
      if (dmw && i_dm_we) begin
        exp_q[s].we    = 1'b1;
        exp_q[s].wdata = i_dm_wdata;
        free_cyc = cyc + 2;
      end else begin
        wd_care[s] = 1'b0;
        last = cyc + RV_OFF;
        for (int k = cyc + 2; k <= last; k++) exp_q[k % 64].busy = 1'b1;
        if (dmw) begin
          exp_q[last % 64].dm_rv = 1'b1;
          exp_q[last % 64].dm_rd = mem_peek(a);
        end else begin
          exp_q[last % 64].if_rv = 1'b1;
          exp_q[last % 64].if_rd = mem_peek(a);
        end
        free_cyc = last + 1;
      end
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 64; k++) begin
      exp_q[k]   = '0;
      wd_care[k] = 1'b1;
    end
    free_cyc = cyc;
    starve   = 0;
  endtask

  task automatic cycle();
    int   s;
    obs_t g;
    @(negedge clk);
    rst_n = s_rst_n;
    s = cyc % 32;
    if (pend_v[s]) begin
      i_mem_rdata = mem_peek(pend_a[s]);
      pend_v[s]   = 1'b0;
    end else begin
      i_mem_rdata = 19'($urandom);
    end
    i_if_req   = s_if_req;
    i_if_addr  = s_if_addr;
    i_dm_req   = s_dm_req;
    i_dm_we    = s_dm_we;
    i_dm_addr  = s_dm_addr;
    i_dm_wdata = s_dm_wdata;
    #1;
    got = '{o_if_gnt, o_dm_gnt, o_if_rvalid, o_if_rdata, o_dm_rvalid, o_dm_rdata,
            o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata, o_busy};
    s = cyc % 64;
    if (chk_en) begin
      g = got;
      if (!wd_care[s]) g.wdata = '0;
      tests++;
      if (g !== exp_q[s]) begin
        fails++;
        $display("FAIL cycle_outputs cyc=%0d got=%h want=%h", cyc, g, exp_q[s]);
      end
    end
    exp_q[s]   = '0;
    wd_care[s] = 1'b1;
    if (got.en) begin
      if (got.we) mem[got.addr] = got.wdata;
      else begin
        pend_v[(cyc + L) % 32] = 1'b1;
        pend_a[(cyc + L) % 32] = got.addr;
      end
    end
    if (rst_n) model_arb();
    cyc++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic [9:0]  order;
    s_rst_n = 1'b0; s_if_req = 1'b0; s_dm_req = 1'b0; s_dm_we = 1'b0;
    s_if_addr = '0; s_dm_addr = '0; s_dm_wdata = '0;
    i_if_req = 1'b0; i_dm_req = 1'b0; i_dm_we = 1'b0;
    i_if_addr = '0; i_dm_addr = '0; i_dm_wdata = '0; i_mem_rdata = '0;
    for (int k = 0; k < 32; k++) pend_v[k] = 1'b0;
    model_reset();

    // Reset state
    s_if_req = 1'b1; s_dm_req = 1'b1;
    repeat (3) cycle();
    check("rst_busy", got.busy, 0);
    check("rst_mem_en", got.en, 0);
    check("rst_gnt", {got.if_gnt, got.dm_gnt}, 0);
    s_if_req = 1'b0; s_dm_req = 1'b0;
    s_rst_n = 1'b1;
    model_reset();
    chk_en = 1'b1;

    // IF read
    mem[19'h00010] = 19'h7FFFF;
    s_if_req = 1'b1; s_if_addr = 19'h00010;
    cycle();
    cycle();
    check("if_gnt", got.if_gnt, 1);
    check("if_mem_en", got.en, 1);
    check("if_mem_we", got.we, 0);
    check("if_mem_addr", got.addr, 32'h10);
    check("if_busy1", got.busy, 1);
    s_if_req = 1'b0;
    for (int k = 2; k <= RV_OFF; k++) begin
      cycle();
      check("if_busy", got.busy, 1);
      check("if_rvalid", got.if_rv, (k == RV_OFF) ? 1 : 0);
    end
    check("if_rdata", got.if_rd, 32'h7FFFF);
    cycle();
    check("if_idle", got.busy, 0);

    // DM write
    s_dm_req = 1'b1; s_dm_we = 1'b1; s_dm_addr = 19'h00100; s_dm_wdata = 19'h12345;
    cycle();
    cycle();
    check("wr_gnt", got.dm_gnt, 1);
    check("wr_mem_we", got.we, 1);
    check("wr_mem_wdata", got.wdata, 32'h12345);
    check("wr_mem_addr", got.addr, 32'h100);
    s_dm_req = 1'b0; s_dm_we = 1'b0;
    cycle();
    check("wr_busy_done", got.busy, 0);
    check("wr_no_rvalid", got.dm_rv, 0);
    cycle();

    // Contention: grants DM x4 then IF, twice
    order = 10'b1000010000;
    n = 0;
    s_if_req = 1'b1; s_if_addr = 19'h00020;
    s_dm_req = 1'b1; s_dm_we = 1'b0; s_dm_addr = 19'h00030;
    for (int b = 0; b < 200 && n < 10; b++) begin
      cycle();
      if (got.if_gnt || got.dm_gnt) begin
        check("contention_order_if", got.if_gnt, order[n]);
        n++;
      end
    end
    check("contention_grants", n, 10);
    s_if_req = 1'b0; s_dm_req = 1'b0;
    repeat (SPACE_RD + 2) cycle();

    // Back-to-back DM reads with DM_REQ held
    s_dm_req = 1'b1; s_dm_we = 1'b0; s_dm_addr = 19'h00040;
    cycle();
    for (int k = 1; k <= RV_OFF + 2 * SPACE_RD; k++) begin
      cycle();
      check("b2b_gnt", got.dm_gnt, (k == 1 || k == 1 + SPACE_RD || k == 1 + 2 * SPACE_RD) ? 1 : 0);
      check("b2b_rvalid", got.dm_rv,
            (k == RV_OFF || k == RV_OFF + SPACE_RD || k == RV_OFF + 2 * SPACE_RD) ? 1 : 0);
      if (k == 1 + 2 * SPACE_RD) s_dm_req = 1'b0;
    end
    repeat (2) cycle();

    // Reset while in WAIT
    s_if_req = 1'b1; s_if_addr = 19'h00050;
    cycle();
    cycle();
    check("rstw_gnt", got.if_gnt, 1);
    s_if_req = 1'b0;
    cycle();
    check("rstw_in_wait", got.busy, 1);
    rst_n = 1'b0;
    #1;
    check("rstw_busy", o_busy, 0);
    check("rstw_outs", {o_if_gnt, o_dm_gnt, o_if_rvalid, o_dm_rvalid, o_mem_en, o_mem_we}, 0);
    check("rstw_rdata", o_if_rdata | o_dm_rdata | o_mem_addr | o_mem_wdata, 0);
    model_reset();
    s_if_req = 1'b1; s_if_addr = 19'h00060;
    cycle();
    check("rstw_no_rvalid", got.if_rv, 0);
    cycle();
    check("rstw_new_gnt", got.if_gnt, 1);
    check("rstw_new_addr", got.addr, 32'h60);
    s_if_req = 1'b0;
    repeat (SPACE_RD + 2) cycle();

    // Random traffic
    for (int r = 0; r < 1500; r++) begin
      if (got.if_gnt || !s_if_req) begin
        s_if_req = ($urandom_range(0, 2) == 0);
        s_if_addr = 19'($urandom_range(0, 15));
      end
      if (got.dm_gnt || !s_dm_req) begin
        s_dm_req = ($urandom_range(0, 1) == 0);
        s_dm_we = $urandom_range(0, 1) == 1;
        s_dm_addr = 19'($urandom_range(0, 15));
        s_dm_wdata = 19'($urandom);
      end
      cycle();
    end
    s_if_req = 1'b0; s_dm_req = 1'b0;
    repeat (SPACE_RD + 4) cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
